// File: rtl/pi_duty_compensator_if.sv
// Error-sample in / duty-command out bundle for the PI compensator.
interface pi_duty_compensator_if #(
    parameter int ERR_W  = 13,
    parameter int DUTY_W = 10
);
    logic              en;
    logic              err_valid;
    logic [ERR_W-1:0]  err_in;
    logic [DUTY_W-1:0] duty;
    logic              duty_valid;
    logic              busy;
    logic              sat_hi;
    logic              sat_lo;
    logic              overrun;

    modport master (
        output en, err_valid, err_in,
        input  duty, duty_valid, busy, sat_hi, sat_lo, overrun
    );

    modport slave (
        input  en, err_valid, err_in,
        output duty, duty_valid, busy, sat_hi, sat_lo, overrun
    );
endinterface

// File: rtl/pi_duty_compensator.sv
// Multi-cycle PI compensator: offset-binary Vout error in, clamped DPWM duty out.
// Optional derivative term is compiled in when PI_DERIV_EN is defined.
module pi_duty_compensator #(
    parameter int ERR_W      = 13,
    parameter int DUTY_W     = 10,
    parameter int KP         = 8,
    parameter int KI         = 1,
    parameter int KD         = 0,
    parameter int GAIN_SHIFT = 6,
    parameter int INT_W      = 24,
    parameter int DUTY_MIN   = 0,
    parameter int DUTY_MAX   = 1000,
    parameter int DUTY_INIT  = 500
) (
    input logic                   CLK20M,
    input logic                   rstHI,
    pi_duty_compensator_if.slave  bus
);
    localparam int E_W = ERR_W + 1;
    localparam int S_W = INT_W + 2;

    localparam logic signed [S_W-1:0]   KP_S     = S_W'(KP);
    localparam logic signed [S_W-1:0]   KI_S     = S_W'(KI);
    localparam logic signed [S_W-1:0]   INT_LO   = S_W'(DUTY_MIN * (2 ** GAIN_SHIFT));
    localparam logic signed [S_W-1:0]   INT_HI   = S_W'(DUTY_MAX * (2 ** GAIN_SHIFT));
    localparam logic signed [INT_W-1:0] INT_INIT = INT_W'(DUTY_INIT * (2 ** GAIN_SHIFT));
    localparam logic signed [S_W-1:0]   U_MIN    = S_W'(DUTY_MIN);
    localparam logic signed [S_W-1:0]   U_MAX    = S_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0]       D_MIN    = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0]       D_MAX    = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0]       D_INIT   = DUTY_W'(DUTY_INIT);

    typedef enum logic [2:0] {IDLE, MULT, ACC, SUM, SAT} state_t;

    state_t                  state_reg, state_next;
    logic signed [E_W-1:0]   e_reg;
    logic signed [S_W-1:0]   p_reg;
    logic signed [S_W-1:0]   ki_reg;
    logic signed [INT_W-1:0] integ_reg;
    logic signed [S_W-1:0]   u_reg;
    logic [DUTY_W-1:0]       duty_sat_reg;
    logic                    hi_pend_reg, lo_pend_reg, out_pend_reg;
    logic [DUTY_W-1:0]       duty_reg;
    logic                    duty_valid_reg, sat_hi_reg, sat_lo_reg, overrun_reg;

    logic signed [E_W-1:0]   e_in;
    logic signed [S_W-1:0]   e_ext, integ_ext, integ_sum, tot, sum_shift;
    logic [DUTY_W-1:0]       duty_clamp;
    logic                    hi_c, lo_c;

    // Offset binary to two's complement: invert the MSB, then sign-extend by one.
    assign e_in      = {~bus.err_in[ERR_W-1], ~bus.err_in[ERR_W-1], bus.err_in[ERR_W-2:0]};
    assign e_ext     = S_W'(e_reg);
    assign integ_ext = S_W'(integ_reg);
    assign integ_sum = integ_ext + ki_reg;
    assign sum_shift = tot >>> GAIN_SHIFT;
    assign hi_c      = (u_reg > U_MAX);
    assign lo_c      = (u_reg < U_MIN);
    assign duty_clamp = hi_c ? D_MAX : (lo_c ? D_MIN : u_reg[DUTY_W-1:0]);

`ifdef PI_DERIV_EN
    localparam logic signed [S_W-1:0] KD_S = S_W'(KD);
    logic signed [E_W-1:0] e_prev_reg;
    logic signed [S_W-1:0] d_reg;
    logic signed [S_W-1:0] e_diff;

    assign e_diff = e_ext - S_W'(e_prev_reg);
    assign tot    = p_reg + integ_ext + d_reg;

    always_ff @(posedge CLK20M or posedge rstHI) begin
        if (rstHI) begin
            e_prev_reg <= '0;
            d_reg      <= '0;
        end else if (!bus.en) begin
            e_prev_reg <= '0;
            d_reg      <= '0;
        end else begin
            if (state_reg == MULT)
                d_reg <= KD_S * e_diff;
            if (state_reg == SAT)
                e_prev_reg <= e_reg;
        end
    end
`else
    assign tot = p_reg + integ_ext;

    // KD only matters on the derivative path.
    if (KD != 0) begin : g_kd_ignored
    end
`endif

    always_ff @(posedge CLK20M or posedge rstHI) begin
        if (rstHI)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (!bus.en) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (bus.err_valid) state_next = MULT;
                MULT:    state_next = ACC;
                ACC:     state_next = SUM;
                SUM:     state_next = SAT;
                SAT:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK20M or posedge rstHI) begin
        if (rstHI) begin
            e_reg          <= '0;
            p_reg          <= '0;
            ki_reg         <= '0;
            integ_reg      <= INT_INIT;
            u_reg          <= '0;
            duty_sat_reg   <= D_INIT;
            hi_pend_reg    <= 1'b0;
            lo_pend_reg    <= 1'b0;
            out_pend_reg   <= 1'b0;
            duty_reg       <= D_INIT;
            duty_valid_reg <= 1'b0;
            sat_hi_reg     <= 1'b0;
            sat_lo_reg     <= 1'b0;
            overrun_reg    <= 1'b0;
        end else if (!bus.en) begin
            integ_reg      <= INT_INIT;
            out_pend_reg   <= 1'b0;
            duty_reg       <= D_INIT;
            duty_valid_reg <= 1'b0;
            sat_hi_reg     <= 1'b0;
            sat_lo_reg     <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            duty_valid_reg <= 1'b0;
            // Clamped result is published one edge after SAT completes.
            if (out_pend_reg) begin
                duty_reg       <= duty_sat_reg;
                sat_hi_reg     <= hi_pend_reg;
                sat_lo_reg     <= lo_pend_reg;
                duty_valid_reg <= 1'b1;
                out_pend_reg   <= 1'b0;
            end
            if (bus.err_valid && state_reg != IDLE)
                overrun_reg <= 1'b1;
            case (state_reg)
                IDLE: if (bus.err_valid) e_reg <= e_in;
                MULT: begin
                    p_reg  <= KP_S * e_ext;
                    ki_reg <= KI_S * e_ext;
                end
                ACC: begin
                    if (integ_sum > INT_HI)
                        integ_reg <= INT_HI[INT_W-1:0];
                    else if (integ_sum < INT_LO)
                        integ_reg <= INT_LO[INT_W-1:0];
                    else
                        integ_reg <= integ_sum[INT_W-1:0];
                end
                SUM: u_reg <= sum_shift;
                SAT: begin
                    duty_sat_reg <= duty_clamp;
                    hi_pend_reg  <= hi_c;
                    lo_pend_reg  <= lo_c;
                    out_pend_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.duty       = duty_reg;
    assign bus.duty_valid = duty_valid_reg;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.sat_hi     = sat_hi_reg;
    assign bus.sat_lo     = sat_lo_reg;
    assign bus.overrun    = overrun_reg;
endmodule

// File: tb/tb_pi_duty_compensator.sv
// Bench for pi_duty_compensator: directed scenarios plus random traffic against a timing/arithmetic model.
module tb_pi_duty_compensator;
`ifdef PI_DERIV_EN
    localparam int KD_TB     = 16;
    localparam int EXP_E64A  = 525;
    localparam int EXP_ZERO  = 0;
    localparam int EXP_ZHI   = 0;
    localparam int EXP_ZLO   = 1;
`else
    localparam int KD_TB     = 0;
    localparam int EXP_E64A  = 509;
    localparam int EXP_ZERO  = 1000;
    localparam int EXP_ZHI   = 0;
    localparam int EXP_ZLO   = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    initial forever #5 clk = ~clk;

    pi_duty_compensator_if #(.ERR_W(13), .DUTY_W(10)) bus ();

    pi_duty_compensator #(.KD(KD_TB)) dut (
        .CLK20M (clk),
        .rstHI  (rst),
        .bus    (bus.slave)
    );

    // Reference model: whole result computed at acceptance, published 5 edges later.
    int m_integ, m_eprev, m_duty, m_res_duty, m_acc_cyc, cyc;
    bit m_res_hi, m_res_lo, m_pend, m_dv, m_busy, m_hi, m_lo, m_ovr;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_idle();
        m_integ = 500 * 64;
        m_eprev = 0;
        m_duty  = 500;
        m_pend  = 0;
        m_dv    = 0;
        m_busy  = 0;
        m_hi    = 0;
        m_lo    = 0;
        m_ovr   = 0;
    endtask

    task automatic model_accept(input int v);
        int e, s, u;
        e        = v - 4096;
        m_integ  = clampi(m_integ + 1 * e, 0, 64000);
        s        = 8 * e + m_integ + KD_TB * (e - m_eprev);
        m_eprev  = e;
        u        = s >>> 6;
        m_res_duty = clampi(u, 0, 1000);
        m_res_hi   = (u > 1000);
        m_res_lo   = (u < 0);
        m_pend     = 1;
        m_acc_cyc  = cyc;
    endtask

    initial begin
        cyc = 0;
        model_idle();
        forever begin
            @(posedge clk);
            cyc++;
            if (rst || !bus.en) begin
                model_idle();
            end else begin
                m_dv = 0;
                if (m_pend && cyc == m_acc_cyc + 5) begin
                    m_duty = m_res_duty;
                    m_hi   = m_res_hi;
                    m_lo   = m_res_lo;
                    m_dv   = 1;
                    m_pend = 0;
                end
                if (bus.err_valid) begin
                    if (m_busy) m_ovr = 1;
                    else        model_accept(int'(bus.err_in));
                end
                m_busy = m_pend && (cyc - m_acc_cyc) <= 3;
            end
        end
    end

    initial begin
        logic [14:0] got, exp_v;
        forever begin
            @(posedge clk);
            #1;
            got   = {bus.duty, bus.duty_valid, bus.busy, bus.sat_hi, bus.sat_lo, bus.overrun};
            exp_v = {10'(m_duty), m_dv, m_busy, m_hi, m_lo, m_ovr};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t: got duty=%0d dv=%b busy=%b hi=%b lo=%b ovr=%b, expected duty=%0d dv=%b busy=%b hi=%b lo=%b ovr=%b",
                         $time, got[14:5], got[4], got[3], got[2], got[1], got[0],
                         exp_v[14:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp_val);
        total++;
        if (act != exp_val) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_val);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [12:0] v);
        bus.err_valid = 1'b1;
        bus.err_in    = v;
        @(negedge clk);
        bus.err_valid = 1'b0;
    endtask

    task automatic wait_dv(output int lat);
        bit seen;
        seen = 0;
        lat  = 0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.duty_valid) seen = 1;
        end
        if (!seen) lat = -1;
        @(negedge clk);
    endtask

    task automatic pulse_check(input string nm, input logic [12:0] v,
                               input int exp_duty, input int exp_hi, input int exp_lo);
        int lat;
        strobe(v);
        wait_dv(lat);
        $display("txn %s err_in=%0d latency=%0d duty=%0d sat_hi=%0d sat_lo=%0d",
                 nm, v, lat, bus.duty, bus.sat_hi, bus.sat_lo);
        check({nm, "_latency"}, lat, 5);
        check({nm, "_duty"}, int'(bus.duty), exp_duty);
        check({nm, "_sat_hi"}, int'(bus.sat_hi), exp_hi);
        check({nm, "_sat_lo"}, int'(bus.sat_lo), exp_lo);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.err_valid = 1'b0;
        bus.err_in    = 13'd4096;
        tick(3);
        check("rst_duty", int'(bus.duty), 500);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_dv", int'(bus.duty_valid), 0);
        check("rst_flags", int'({bus.sat_hi, bus.sat_lo, bus.overrun}), 0);
        rst    = 1'b0;
        bus.en = 1'b1;
        tick(2);

        pulse_check("mid", 13'd4096, 500, 0, 0);

        do_reset();
        pulse_check("e64_a", 13'd4160, EXP_E64A, 0, 0);
        tick(2);
        pulse_check("e64_b", 13'd4160, 510, 0, 0);

        do_reset();
        pulse_check("emax", 13'd8191, 1000, 1, 0);
        do_reset();
        pulse_check("emin", 13'd0, 0, 0, 1);

        // Windup: integrator must pin at DUTY_MAX<<GAIN_SHIFT.
        do_reset();
        repeat (40) begin
            strobe(13'd8191);
            tick(6);
        end
        check("windup_model_integ", m_integ, 64000);
        check("windup_duty", int'(bus.duty), 1000);
        pulse_check("zero_after_windup", 13'd4096, EXP_ZERO, EXP_ZHI, EXP_ZLO);
        pulse_check("neg1_after_windup", 13'd4095, 999, 0, 0);

        // Overrun then reset while a sample sits in ACC.
        do_reset();
        tick(1);
        bus.err_valid = 1'b1; bus.err_in = 13'd4160;
        @(negedge clk);
        bus.err_valid = 1'b0;
        @(negedge clk);
        bus.err_valid = 1'b1; bus.err_in = 13'd4200;
        @(negedge clk);
        bus.err_valid = 1'b0;
        check("overrun_set", int'(bus.overrun), 1);
        @(negedge clk);
        @(negedge clk);
        bus.err_valid = 1'b1; bus.err_in = 13'd4300;
        @(posedge clk);
        #1;
        check("ovr_dv_at_n5", int'(bus.duty_valid), 1);
        check("ovr_duty_at_n5", int'(bus.duty), EXP_E64A);
        @(negedge clk);
        bus.err_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_duty", int'(bus.duty), 500);
        check("abort_overrun", int'(bus.overrun), 0);
        check("abort_busy", int'(bus.busy), 0);
        tick(2);
        rst = 1'b0;
        n = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.duty_valid) n++;
        end
        check("abort_no_pulse", n, 0);
        @(negedge clk);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            if (bus.en) bus.en = ($urandom_range(0, 99) != 0);
            else        bus.en = ($urandom_range(0, 4) == 0);
            bus.err_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0)
                bus.err_in = 13'(4096 + $urandom_range(0, 400) - 200);
            else
                bus.err_in = 13'($urandom_range(0, 8191));
        end
        @(negedge clk);
        rst = 1'b0;
        bus.err_valid = 1'b0;
        tick(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
